// File: rtl/parking_gate_controller.sv
// Single-lane car park gate controller: keypad entry, lockout, occupancy.
// Optional idle-keypad timeout enabled by defining PARK_TIMEOUT_EN.
module parking_gate_controller #(
   parameter int                  PW_WIDTH       = 4,
   parameter logic [PW_WIDTH-1:0] PASSWORD       = 4'hA,
   parameter int                  CAPACITY       = 8,
   parameter int                  MAX_ATTEMPTS   = 3,
   parameter int                  LOCKOUT_CYCLES = 16,
   parameter int                  TIMEOUT_CYCLES = 64
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic                             front_sensor,
   input  logic                             back_sensor,
   input  logic                             exit_sensor,
   input  logic [PW_WIDTH-1:0]              password,
   input  logic                             password_valid,
   output logic                             green_LED,
   output logic                             red_LED,
   output logic [2:0]                       display_screen,
   output logic [$clog2(CAPACITY+1)-1:0]    occupancy,
   output logic                             full,
   output logic                             locked
);

   localparam int OW = $clog2(CAPACITY + 1);
   localparam int AW = $clog2(MAX_ATTEMPTS + 1);
   localparam int LW = $clog2(LOCKOUT_CYCLES + 1);

   localparam logic [OW-1:0] CAP  = OW'(CAPACITY);
   localparam logic [LW-1:0] LMAX = LW'(LOCKOUT_CYCLES - 1);

   // Parameter sanity: every count must be at least one.
   if (CAPACITY < 1 || MAX_ATTEMPTS < 1 ||
       LOCKOUT_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
      $error("parking_gate_controller: parameters must be >= 1");
   end

   typedef enum logic [2:0] {
      S_IDLE  = 3'b000,
      S_WAIT  = 3'b001,
      S_WRONG = 3'b010,
      S_RIGHT = 3'b011,
      S_STOP  = 3'b100,
      S_LOCK  = 3'b101,
      S_FULL  = 3'b110
   } state_t;

   state_t          state;
   state_t          nxt;
   logic [AW-1:0]   attempts;
   logic [AW-1:0]   att_nxt;
   logic [LW-1:0]   lock_cnt;
   logic [LW-1:0]   lcnt_nxt;
   logic [OW-1:0]   occ_nxt;
   logic            inc;
   logic            tout;
   logic            exit_prev;
   logic            exit_edge;

`ifdef PARK_TIMEOUT_EN
   localparam int            TW   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

   logic [TW-1:0] tcnt;
   logic [TW-1:0] tcnt_nxt;

   assign tout = (tcnt == TMAX) && !front_sensor;
`else
   assign tout = 1'b0;
`endif

   // Exit sensor rising edge, registered so it lands one cycle later.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         exit_prev <= 1'b0;
         exit_edge <= 1'b0;
      end else begin
         exit_prev <= exit_sensor;
         exit_edge <= exit_sensor & ~exit_prev;
      end
   end

   // Next-state, attempt, lockout and occupancy decisions.
   always_comb begin
      nxt      = state;
      att_nxt  = attempts;
      lcnt_nxt = '0;
      inc      = 1'b0;
      occ_nxt  = occupancy;
      unique case (state)
         S_IDLE: begin
            if (front_sensor)
               nxt = (occupancy == CAP) ? S_FULL : S_WAIT;
         end
         S_WAIT, S_WRONG, S_STOP: begin
            if (password_valid) begin
               if (password == PASSWORD) begin
                  nxt     = S_RIGHT;
                  att_nxt = '0;
               end else begin
                  att_nxt = attempts + 1'b1;
                  if (int'(attempts) + 1 >= MAX_ATTEMPTS)
                     nxt = S_LOCK;
                  else
                     nxt = S_WRONG;
               end
            end else if (tout && state != S_STOP) begin
               nxt     = S_IDLE;
               att_nxt = '0;
            end
         end
         S_RIGHT: begin
            if (back_sensor) begin
               inc = 1'b1;
               nxt = front_sensor ? S_STOP : S_IDLE;
            end
         end
         S_LOCK: begin
            if (lock_cnt == LMAX) begin
               nxt     = S_IDLE;
               att_nxt = '0;
            end else begin
               lcnt_nxt = lock_cnt + 1'b1;
            end
         end
         S_FULL: begin
            if (occupancy < CAP)
               nxt = front_sensor ? S_WAIT : S_IDLE;
         end
         default: begin
            nxt = S_IDLE;
         end
      endcase
      if (inc && !exit_edge && occupancy != CAP)
         occ_nxt = occupancy + 1'b1;
      else if (exit_edge && !inc && occupancy != '0)
         occ_nxt = occupancy - 1'b1;
   end

   // State register with Moore outputs registered from the next state.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state          <= S_IDLE;
         attempts       <= '0;
         lock_cnt       <= '0;
         occupancy      <= '0;
         full           <= 1'b0;
         green_LED      <= 1'b0;
         red_LED        <= 1'b0;
         locked         <= 1'b0;
         display_screen <= 3'b000;
      end else begin
         state          <= nxt;
         attempts       <= att_nxt;
         lock_cnt       <= lcnt_nxt;
         occupancy      <= occ_nxt;
         full           <= (occ_nxt == CAP);
         green_LED      <= (nxt == S_RIGHT);
         red_LED        <= !(nxt == S_IDLE || nxt == S_RIGHT);
         locked         <= (nxt == S_LOCK);
         display_screen <= nxt;
      end
   end

`ifdef PARK_TIMEOUT_EN
   // Idle-keypad timer: restarts on any strobe or state change.
   always_comb begin
      tcnt_nxt = '0;
      if ((state == S_WAIT || state == S_WRONG) &&
          nxt == state && !password_valid)
         tcnt_nxt = (tcnt == TMAX) ? tcnt : tcnt + 1'b1;
   end

   // Timer register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         tcnt <= '0;
      else
         tcnt <= tcnt_nxt;
   end
`endif

endmodule
